// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master sequencer:
//   - FSM state encoding of the transfer sequencer
//   - one-hot PSEL codes for the GPIO and UART slave interfaces
//   - address region constants and the position of the region field
//   - apb_decode(): maps a region nibble to {hit, psel}
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] PSEL_NONE = 2'b00;
    localparam logic [1:0] PSEL_GPIO = 2'b01;
    localparam logic [1:0] PSEL_UART = 2'b10;

    localparam logic [3:0] REG_GPIO = 4'h0;
    localparam logic [3:0] REG_UART = 4'h1;

    // Region field inside the 32-bit address.
    localparam int REG_MSB = 15;
    localparam int REG_LSB = 12;

    typedef struct packed {
        logic       hit;   // address maps to a known slave
        logic [1:0] psel;  // one-hot select, PSEL_NONE on a miss
    } apb_decode_t;

    function automatic apb_decode_t apb_decode(input logic [3:0] region);
        apb_decode_t d;
        d.hit  = 1'b1;
        d.psel = PSEL_NONE;
        case (region)
            REG_GPIO: d.psel = PSEL_GPIO;
            REG_UART: d.psel = PSEL_UART;
            default:  d.hit  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. The grant is a pure
// function of the request vector and the pointer; the pointer moves to one past
// the winner whenever i_advance is pulsed, making the last winner lowest
// priority. After reset requester 0 has the highest priority.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_req        request vector, one bit per requester
//   i_advance    accept strobe: rotate the pointer past the current winner
//   o_grant      one-hot grant (all zero when no request)
//   o_grant_idx  binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_grant_idx
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;
    logic          w_found;

    // Scan requesters starting at the pointer, first hit wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned; otherwise synthesis infers a latch.
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
                w_found         = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_ptr <= (o_grant_idx == PW'(NREQ - 1)) ? '0 : o_grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
// APB master sequencer sharing one APB bus between NREQ requesters.
// Requests are arbitrated round-robin, the address is decoded to a one-hot
// PSEL (GPIO/UART) and the SETUP/ACCESS protocol is driven; the result
// (read data or error) returns to the granted requester as a one-cycle pulse.
// Sequence: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. A request is accepted on
// the edge that enters IDLE, so req_ready is visible during the IDLE cycle
// and the bus idles exactly two cycles (RESP, IDLE) between transfers.
// All outputs come straight from flops.
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   req_valid/req_write  per-requester request and direction
//   req_addr/req_wdata   packed per-requester address / write data
//   req_ready            one-cycle one-hot accept pulse
//   rsp_valid            one-cycle one-hot completion pulse
//   rsp_rdata/rsp_err    read data (0 on write/error) and error flag
//   PADDR..PPROT         APB master outputs
//   PRDATA/PREADY/PSLVERR APB slave responses
// -----------------------------------------------------------------------------
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int         NREQ    = 2,
    parameter int         TIMEOUT = 16,
    parameter logic [2:0] PPROT_V = 3'b000
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    output logic                 PWRITE,
    output logic [1:0]           PSEL,
    output logic                 PENABLE,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    apb_state_e     r_state;
    apb_state_e     w_state_nxt;
    logic           w_accept;
    logic           w_timeout;
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]  w_grant_idx;
    logic [31:0]    w_sel_addr;

    logic [NREQ-1:0] r_req_ready;
    logic [NREQ-1:0] r_gnt;
    logic [31:0]    r_paddr;
    logic [31:0]    r_pwdata;
    logic           r_pwrite;
    apb_decode_t    r_dec;
    logic [1:0]     r_psel;
    logic           r_penable;
    logic [CW-1:0]  r_wait_cnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic           r_rsp_err;
    logic [31:0]    r_rsp_rdata;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_clk       (PCLK),
        .i_rst_n     (PRESETn),
        .i_req       (req_valid),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_sel_addr = req_addr[int'(w_grant_idx)*32 +: 32];
    assign w_timeout  = (r_wait_cnt == CW'(TIMEOUT - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // r_req_ready non-zero marks the accept cycle.
            ST_IDLE:   if (|r_req_ready) w_state_nxt = r_dec.hit ? ST_SETUP : ST_RESP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (PREADY || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // Sample requesters only on the edge that lands in a fresh IDLE cycle.
        w_accept = (w_state_nxt == ST_IDLE) && (|req_valid);
    end

    // ---------------- Datapath and registered outputs ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_req_ready <= '0;
            r_gnt       <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_dec       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req_ready <= w_accept ? w_grant : '0;
            if (w_accept) begin
                r_gnt    <= w_grant;
                r_paddr  <= w_sel_addr;
                r_pwdata <= req_wdata[int'(w_grant_idx)*32 +: 32];
                r_pwrite <= req_write[w_grant_idx];
                r_dec    <= apb_decode(w_sel_addr[REG_MSB:REG_LSB]);
            end

            r_psel    <= (w_state_nxt == ST_SETUP || w_state_nxt == ST_ACCESS) ? r_dec.psel : '0;
            r_penable <= (w_state_nxt == ST_ACCESS);

            // Counts consecutive PREADY-low ACCESS cycles of the current transfer.
            if (r_state == ST_ACCESS && !PREADY) r_wait_cnt <= r_wait_cnt + CW'(1);
            else                                 r_wait_cnt <= '0;

            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_state_nxt == ST_RESP) begin
                r_rsp_valid <= r_gnt;
                if (r_state == ST_ACCESS && PREADY) begin
                    r_rsp_err   <= PSLVERR;
                    r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                end else begin
                    // Decode miss from IDLE or timeout from ACCESS.
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PPROT     = PPROT_V;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
// Directed bench for apb_master_ctrl (NREQ=2, TIMEOUT=16). Expected responses
// are pushed to a scoreboard queue at accept time and popped when rsp_valid
// appears. The bench plays the APB slave, driving PREADY/PRDATA/PSLVERR at the
// falling edge, and keeps its own round-robin pointer model.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic                PCLK = 1'b0;
    logic                PRESETn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*32-1:0]  req_addr;
    logic [NREQ*32-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [31:0]         PADDR;
    logic [31:0]         PWDATA;
    logic                PWRITE;
    logic [1:0]          PSEL;
    logic                PENABLE;
    logic [2:0]          PPROT;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          model_ptr = 0;
    exp_t        sb[$];
    logic [31:0] a_addr  [NREQ];
    logic [31:0] a_wdata [NREQ];
    logic        a_wr    [NREQ];

    apb_master_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .PPROT_V(3'b000)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int i);
        return 2'(1 << i);
    endfunction

    // Region [15:12]: 0 -> GPIO, 1 -> UART, otherwise no slave.
    function automatic logic [1:0] exp_psel(input logic [31:0] addr);
        logic [3:0] r;
        r = addr[15:12];
        if (r == 4'h0) return 2'b01;
        if (r == 4'h1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
        a_wr[i]    = wr;
        a_addr[i]  = addr;
        a_wdata[i] = wdata;
        req_write[i]          = wr;
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wdata;
    endtask

    // One complete transfer. Called and returning at a falling edge; returns
    // on the falling edge of the RESP cycle.
    task automatic xfer(input logic [NREQ-1:0] mask, input int waits,
                        input logic [31:0] rd, input logic serr, input bit hang,
                        input bit drop_win, input bit drop_all);
        int          g;
        int          n;
        int          t0;
        int          exp_lat;
        logic [1:0]  epsel;
        exp_t        e;
        exp_t        o;
        req_valid = req_valid | mask;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (req_ready === '0 && n < 20);
        check("accept_seen", {31'b0, |req_ready}, 32'd1);
        g = model_pick(req_valid);
        check("req_ready_grant", {30'b0, req_ready}, {30'b0, onehot(g)});
        model_ptr = (g + 1) % NREQ;
        t0    = cyc;
        epsel = exp_psel(a_addr[g]);
        e.idx   = g;
        e.err   = (epsel == 2'b00) || hang || serr;
        e.rdata = (e.err || a_wr[g]) ? 32'h0 : rd;
        sb.push_back(e);
        if (drop_win) req_valid[g] = 1'b0;

        @(negedge PCLK);
        check("req_ready_pulse", {30'b0, req_ready}, 32'h0);
        if (epsel != 2'b00) begin
            check("setup_psel",    {30'b0, PSEL}, {30'b0, epsel});
            check("setup_penable", {31'b0, PENABLE}, 32'h0);
            check("setup_paddr",   PADDR, a_addr[g]);
            check("setup_pwrite",  {31'b0, PWRITE}, {31'b0, a_wr[g]});
            if (a_wr[g]) check("setup_pwdata", PWDATA, a_wdata[g]);
            // Bus responses outside ACCESS must be ignored.
            PREADY  = 1'b1;
            PRDATA  = 32'hBAD0_BAD0;
            PSLVERR = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge PCLK);
                if (rsp_valid !== '0) break;
                check("access_psel",    {30'b0, PSEL}, {30'b0, epsel});
                check("access_penable", {31'b0, PENABLE}, 32'd1);
                PREADY  = !hang && (k >= waits);
                PRDATA  = PREADY ? rd : 32'hDEAD_BEEF;
                PSLVERR = PREADY ? serr : 1'b1;
            end
            PREADY  = 1'b0;
            PRDATA  = 32'h0;
            PSLVERR = 1'b0;
            exp_lat = hang ? (2 + TIMEOUT) : (3 + waits);
        end else begin
            exp_lat = 1;
        end
        check("rsp_latency", cyc - t0, exp_lat);
        o = sb.pop_front();
        check("rsp_valid",   {30'b0, rsp_valid}, {30'b0, onehot(o.idx)});
        check("rsp_err",     {31'b0, rsp_err}, {31'b0, o.err});
        check("rsp_rdata",   rsp_rdata, o.rdata);
        check("resp_psel",   {30'b0, PSEL}, 32'h0);
        check("resp_penable", {31'b0, PENABLE}, 32'h0);
        if (drop_all) req_valid = '0;
    endtask

    initial begin
        int n;
        PRESETn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_psel",      {30'b0, PSEL}, 32'h0);
        check("rst_penable",   {31'b0, PENABLE}, 32'h0);
        check("rst_req_ready", {30'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        check("rst_paddr",     PADDR, 32'h0);
        check("rst_pprot",     {29'b0, PPROT}, 32'h0);
        PRESETn = 1'b1;

        // 1: req0 write GPIO, zero-wait slave
        set_req(0, 1'b1, 32'h0000_0004, 32'h0000_00A5);
        xfer(2'b01, 0, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 1'b0);

        // 2: req1 read UART, two wait states
        set_req(1, 1'b0, 32'h0000_1000, 32'h0);
        xfer(2'b10, 2, 32'h0000_003C, 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: both requesters continuously valid -> 0,1,0,1
        set_req(0, 1'b1, 32'h0000_0010, 32'h0000_0011);
        set_req(1, 1'b0, 32'h0000_1004, 32'h0);
        xfer(2'b11, 0, 32'h3C3C_0077, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(2'b11, 1, 32'h3C3C_0078, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(2'b11, 0, 32'h3C3C_0079, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(2'b11, 0, 32'h3C3C_007A, 1'b0, 1'b0, 1'b0, 1'b1);

        // 4: decode miss, then PSLVERR, then a lone requester 1 again
        set_req(0, 1'b0, 32'h0000_5000, 32'h0);
        xfer(2'b01, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0);
        set_req(1, 1'b1, 32'h0000_1008, 32'h0000_00EE);
        xfer(2'b10, 1, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 1'b0);
        set_req(1, 1'b0, 32'h0000_100C, 32'h0);
        xfer(2'b10, 0, 32'h0000_00C3, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: slave never ready -> timeout
        set_req(0, 1'b0, 32'h0000_0000, 32'h0);
        xfer(2'b01, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);

        // 6: reset during ACCESS, req0 stays pending
        set_req(0, 1'b0, 32'h0000_0008, 32'h0);
        req_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (req_ready === '0 && n < 20);
        check("t6_accept", {30'b0, req_ready}, 32'h1);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (PENABLE !== 1'b1 && n < 20);
        check("t6_in_access", {31'b0, PENABLE}, 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check("t6_psel",      {30'b0, PSEL}, 32'h0);
        check("t6_penable",   {31'b0, PENABLE}, 32'h0);
        check("t6_paddr",     PADDR, 32'h0);
        check("t6_pwrite",    {31'b0, PWRITE}, 32'h0);
        check("t6_pwdata",    PWDATA, 32'h0);
        check("t6_req_ready", {30'b0, req_ready}, 32'h0);
        check("t6_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        check("t6_rsp_err",   {31'b0, rsp_err}, 32'h0);
        check("t6_rsp_rdata", rsp_rdata, 32'h0);
        repeat (3) begin
            @(negedge PCLK);
            check("t6_no_rsp", {30'b0, rsp_valid}, 32'h0);
        end
        PRESETn   = 1'b1;
        model_ptr = 0;
        xfer(2'b01, 0, 32'h5A5A_0001, 1'b0, 1'b0, 1'b1, 1'b0);

        check("sb_empty", sb.size(), 32'h0);
        repeat (2) @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
